// File: rtl/periodic_framer_v2.sv
// Periodic AXI-stream framer: after a trigger it drops an offset, then alternates
// guard gaps and fixed-length frames (tagged with tlast and a frame index).
module periodic_framer_v2 #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SR_BASE   = 16,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  input  logic                 trigger,
  input  logic [WIDTH-1:0]     i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [WIDTH-1:0]     o_tdata,
  output logic                 o_tlast,
  output logic [CNT_WIDTH-1:0] o_tuser,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 busy
);

  localparam logic [7:0] A_FRAME  = 8'(SR_BASE);
  localparam logic [7:0] A_GAP    = 8'(SR_BASE + 1);
  localparam logic [7:0] A_OFFSET = 8'(SR_BASE + 2);
  localparam logic [7:0] A_MAX    = 8'(SR_BASE + 3);
  localparam logic [7:0] A_CTRL   = 8'(SR_BASE + 4);

  typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_GAP, S_FRAME} state_e;

  logic [LEN_WIDTH-1:0] frame_len_q, gap_len_q, offset_q;
  logic [CNT_WIDTH-1:0] max_frames_q;
  logic                 gap_first_q, retrig_en_q;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] fdone_q, fdone_d;
  logic                 pend_q, pend_d;
  logic                 abort_pend_q, abort_pend_d;
  logic [LEN_WIDTH-1:0] sh_frame_q, sh_frame_d, sh_gap_q, sh_gap_d;
  logic [CNT_WIDTH-1:0] sh_max_q, sh_max_d;
  logic                 sh_gap_first_q, sh_gap_first_d;

  logic                 abort_c, trig_c, start_ok_c, beat_c, last_beat_c, restart_c;
  logic [CNT_WIDTH-1:0] fdone_inc_c;
  logic                 unused_bits;

  assign unused_bits = ^set_data;

  assign abort_c     = set_stb && (set_addr == A_CTRL) && set_data[2];
  assign trig_c      = trigger && !abort_c;
  assign start_ok_c  = trig_c && (frame_len_q != '0);
  assign beat_c      = i_tvalid && i_tready;
  assign last_beat_c = (cnt_q == LEN_WIDTH'(1));
  assign fdone_inc_c = fdone_q + CNT_WIDTH'(1);

  // Settings registers; the abort bit is a strobe and is never stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_len_q  <= LEN_WIDTH'(64);
      gap_len_q    <= LEN_WIDTH'(16);
      offset_q     <= '0;
      max_frames_q <= '0;
      gap_first_q  <= 1'b1;
      retrig_en_q  <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == A_FRAME)  frame_len_q  <= LEN_WIDTH'(set_data);
      if (set_addr == A_GAP)    gap_len_q    <= LEN_WIDTH'(set_data);
      if (set_addr == A_OFFSET) offset_q     <= LEN_WIDTH'(set_data);
      if (set_addr == A_MAX)    max_frames_q <= CNT_WIDTH'(set_data);
      if (set_addr == A_CTRL) begin
        gap_first_q <= set_data[0];
        retrig_en_q <= set_data[1];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fdone_d        = fdone_q;
    pend_d         = pend_q;
    abort_pend_d   = abort_pend_q;
    sh_frame_d     = sh_frame_q;
    sh_gap_d       = sh_gap_q;
    sh_max_d       = sh_max_q;
    sh_gap_first_d = sh_gap_first_q;
    restart_c      = 1'b0;

    case (state_q)
      S_IDLE: restart_c = start_ok_c;
      S_OFFSET, S_GAP: begin
        if (abort_c) begin
          state_d = S_IDLE;
        end else if (start_ok_c && retrig_en_q) begin
          restart_c = 1'b1;
        end else if (beat_c && i_tlast) begin
          state_d = S_IDLE;
        end else if (beat_c) begin
          if (!last_beat_c) begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end else if ((state_q == S_OFFSET) && sh_gap_first_q && (sh_gap_q != '0)) begin
            state_d = S_GAP;
            cnt_d   = sh_gap_q;
          end else begin
            state_d = S_FRAME;
            cnt_d   = sh_frame_q;
          end
        end
      end
      S_FRAME: begin
        // Abort and retrigger in a frame are deferred to its final beat.
        if (abort_c) begin
          abort_pend_d = 1'b1;
          pend_d       = 1'b0;
        end else if (trig_c && retrig_en_q) begin
          pend_d = 1'b1;
        end
        if (beat_c) begin
          if (last_beat_c) begin
            fdone_d = fdone_inc_c;
            cnt_d   = sh_frame_q;
            if (i_tlast || abort_pend_q || abort_c) begin
              state_d = S_IDLE;
            end else if (pend_q || (trig_c && retrig_en_q)) begin
              restart_c = 1'b1;
            end else if ((sh_max_q != '0) && (fdone_inc_c == sh_max_q)) begin
              state_d = S_IDLE;
            end else if (sh_gap_q != '0) begin
              state_d = S_GAP;
              cnt_d   = sh_gap_q;
            end
          end else if (i_tlast) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // New run: capture live settings and enter the first non-empty stage.
    if (restart_c) begin
      sh_frame_d     = frame_len_q;
      sh_gap_d       = gap_len_q;
      sh_max_d       = max_frames_q;
      sh_gap_first_d = gap_first_q;
      fdone_d        = '0;
      if (frame_len_q == '0) begin
        state_d = S_IDLE;
      end else if (offset_q != '0) begin
        state_d = S_OFFSET;
        cnt_d   = offset_q;
      end else if (gap_first_q && (gap_len_q != '0)) begin
        state_d = S_GAP;
        cnt_d   = gap_len_q;
      end else begin
        state_d = S_FRAME;
        cnt_d   = frame_len_q;
      end
    end

    if (restart_c || (state_d == S_IDLE)) begin
      pend_d       = 1'b0;
      abort_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      fdone_q        <= '0;
      pend_q         <= 1'b0;
      abort_pend_q   <= 1'b0;
      sh_frame_q     <= LEN_WIDTH'(64);
      sh_gap_q       <= LEN_WIDTH'(16);
      sh_max_q       <= '0;
      sh_gap_first_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fdone_q        <= fdone_d;
      pend_q         <= pend_d;
      abort_pend_q   <= abort_pend_d;
      sh_frame_q     <= sh_frame_d;
      sh_gap_q       <= sh_gap_d;
      sh_max_q       <= sh_max_d;
      sh_gap_first_q <= sh_gap_first_d;
    end
  end

  // Zero-latency pass-through; drop states sink input unconditionally.
  assign i_tready = reset_n && ((state_q == S_FRAME) ? o_tready : 1'b1);
  assign o_tvalid = (state_q == S_FRAME) && i_tvalid;
  assign o_tlast  = (state_q == S_FRAME) && (last_beat_c || i_tlast);
  assign o_tdata  = i_tdata;
  assign o_tuser  = fdone_q;
  assign busy     = (state_q != S_IDLE);

endmodule
